// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: decode-to-execute bundle with RV32I opcode/control-word types
package id_ex_pkg;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_CSR   = 7'b1110011;
  typedef struct packed {
    logic       load_regfile;
    logic       data_mem_read;
    logic       data_mem_write;
    logic [2:0] alu_op;
    logic       alu_imm;
    logic [1:0] wb_sel;
  } rv32i_control_word;
endpackage

interface id_ex_stage_reg_if #(parameter int CNT_W = 16);
  logic                          id_valid;
  logic [6:0]                    id_opcode;
  id_ex_pkg::rv32i_control_word  id_ctrl;
  logic [31:0]                   id_pc;
  logic [4:0]                    id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0]                   id_rs1_data, id_rs2_data;
  logic [159:0]                  id_imms;
  logic                          mem_stall;
  logic                          flush;
  logic                          ex_valid;
  id_ex_pkg::rv32i_control_word  ex_ctrl;
  logic [31:0]                   ex_pc, ex_rs1_data, ex_rs2_data;
  logic [4:0]                    ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [159:0]                  ex_imms;
  logic                          ifid_stall;
  logic [CNT_W-1:0]              bubble_count, flush_count;
  modport master (
    output id_valid, id_opcode, id_ctrl, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_rs1_data, id_rs2_data, id_imms, mem_stall, flush,
    input  ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr,
           ex_rd_addr, ex_imms, ifid_stall, bubble_count, flush_count
  );
  modport slave (
    input  id_valid, id_opcode, id_ctrl, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_rs1_data, id_rs2_data, id_imms, mem_stall, flush,
    output ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr,
           ex_rd_addr, ex_imms, ifid_stall, bubble_count, flush_count
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble insertion, redirect squash and perf counters
module id_ex_stage_reg #(parameter int CNT_W = 16) (
  input logic              clk,
  input logic              rst_n,
  id_ex_stage_reg_if.slave bus
);
  import id_ex_pkg::*;
  typedef struct packed {
    logic              valid;
    rv32i_control_word ctrl;
    logic [31:0]       pc, rs1_data, rs2_data;
    logic [4:0]        rs1_addr, rs2_addr, rd_addr;
    logic [159:0]      imms;
  } ex_t;
  ex_t              ex_d, ex_q, cap;
  logic [CNT_W-1:0] bubble_d, bubble_q, flush_d, flush_q;
  logic             uses_rs1, uses_rs2, hazard;
  always_comb begin
    uses_rs1 = bus.id_opcode inside {OP_JALR, OP_BR, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
    uses_rs2 = bus.id_opcode inside {OP_BR, OP_STORE, OP_REG};
    hazard   = ex_q.valid & ex_q.ctrl.data_mem_read & ex_q.ctrl.load_regfile & (ex_q.rd_addr != 5'd0)
             & bus.id_valid & ((uses_rs1 & (bus.id_rs1_addr == ex_q.rd_addr))
             | (uses_rs2 & (bus.id_rs2_addr == ex_q.rd_addr)));
    // an invalid capture still copies data but must never carry write enables into EX
    cap      = '{valid: bus.id_valid, ctrl: bus.id_valid ? bus.id_ctrl : '0, pc: bus.id_pc,
                 rs1_data: bus.id_rs1_data, rs2_data: bus.id_rs2_data, rs1_addr: bus.id_rs1_addr,
                 rs2_addr: bus.id_rs2_addr, rd_addr: bus.id_rd_addr, imms: bus.id_imms};
    ex_d     = bus.mem_stall ? ex_q : (bus.flush | hazard) ? '0 : cap;
    bubble_d = bubble_q + {{(CNT_W-1){1'b0}}, ~bus.mem_stall & ~bus.flush & hazard & ~&bubble_q};
    flush_d  = flush_q + {{(CNT_W-1){1'b0}}, ~bus.mem_stall & bus.flush & ~&flush_q};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q     <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      ex_q     <= ex_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end
  assign bus.ifid_stall   = rst_n & ~bus.mem_stall & ~bus.flush & hazard;
  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_ctrl      = ex_q.ctrl;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_rs1_data  = ex_q.rs1_data;
  assign bus.ex_rs2_data  = ex_q.rs2_data;
  assign bus.ex_rs1_addr  = ex_q.rs1_addr;
  assign bus.ex_rs2_addr  = ex_q.rs2_addr;
  assign bus.ex_rd_addr   = ex_q.rd_addr;
  assign bus.ex_imms      = ex_q.imms;
  assign bus.bubble_count = bubble_q;
  assign bus.flush_count  = flush_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: scoreboard bench comparing the stage against an instruction-level reference model
module tb_id_ex_stage_reg;
  import id_ex_pkg::*;
  typedef struct packed {
    logic              valid;
    rv32i_control_word ctrl;
    logic [31:0]       pc, d1, d2;
    logic [4:0]        a1, a2, rd;
    logic [159:0]      imms;
  } ex_t;
  typedef struct {
    logic stall;
    ex_t  ex;
    int   bc, fc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  exp_t q[$];
  int   checks = 0, errors = 0;
  ex_t  m;
  int   mbc, mfc;
  logic [6:0] ops [10];
  id_ex_stage_reg_if #(.CNT_W(16)) bus();
  id_ex_stage_reg_if #(.CNT_W(2))  sbus();
  id_ex_stage_reg #(.CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  id_ex_stage_reg #(.CNT_W(2))  u_sat (.clk(clk), .rst_n(rst_n), .bus(sbus));
  assign sbus.id_valid    = bus.id_valid;
  assign sbus.id_opcode   = bus.id_opcode;
  assign sbus.id_ctrl     = bus.id_ctrl;
  assign sbus.id_pc       = bus.id_pc;
  assign sbus.id_rs1_addr = bus.id_rs1_addr;
  assign sbus.id_rs2_addr = bus.id_rs2_addr;
  assign sbus.id_rd_addr  = bus.id_rd_addr;
  assign sbus.id_rs1_data = bus.id_rs1_data;
  assign sbus.id_rs2_data = bus.id_rs2_data;
  assign sbus.id_imms     = bus.id_imms;
  assign sbus.mem_stall   = bus.mem_stall;
  assign sbus.flush       = bus.flush;
  always #5 clk = ~clk;

  function automatic bit reads_rs1(logic [6:0] op);
    return op inside {OP_JALR, OP_BR, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
  endfunction
  function automatic bit reads_rs2(logic [6:0] op);
    return op inside {OP_BR, OP_STORE, OP_REG};
  endfunction
  function automatic rv32i_control_word mkc(bit lr, bit mr, bit mw);
    rv32i_control_word c;
    c = rv32i_control_word'($urandom);
    c.load_regfile = lr;
    c.data_mem_read = mr;
    c.data_mem_write = mw;
    return c;
  endfunction
  function automatic int sat(int v, int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic chk(string n, logic [511:0] a, logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // one cycle: drive ID inputs at the negedge and predict the outcome of the next rising edge
  task automatic step(bit rs, bit v, logic [6:0] op, rv32i_control_word c,
                      logic [4:0] a1, logic [4:0] a2, logic [4:0] rd, bit ms, bit fl);
    exp_t e;
    bit   hz;
    @(negedge clk);
    rst_n = rs;
    bus.id_valid = v;
    bus.id_opcode = op;
    bus.id_ctrl = c;
    bus.id_pc = $urandom;
    bus.id_rs1_addr = a1;
    bus.id_rs2_addr = a2;
    bus.id_rd_addr = rd;
    bus.id_rs1_data = $urandom;
    bus.id_rs2_data = $urandom;
    bus.id_imms = {$urandom, $urandom, $urandom, $urandom, $urandom};
    bus.mem_stall = ms;
    bus.flush = fl;
    hz = m.valid && m.ctrl.data_mem_read && m.ctrl.load_regfile && m.rd != 0 && v &&
         ((reads_rs1(op) && a1 == m.rd) || (reads_rs2(op) && a2 == m.rd));
    e.stall = rs && !ms && !fl && hz;
    if (!rs) begin
      m = '0; mbc = 0; mfc = 0;
    end else if (ms) begin
    end else if (fl) begin
      m = '0; mfc++;
    end else if (hz) begin
      m = '0; mbc++;
    end else begin
      m = '{v, v ? c : rv32i_control_word'(0), bus.id_pc, bus.id_rs1_data, bus.id_rs2_data,
            a1, a2, rd, bus.id_imms};
    end
    e.ex = m;
    e.bc = mbc;
    e.fc = mfc;
    q.push_back(e);
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] l [4];
    l = '{5'd0, 5'd5, 5'd6, 5'd7};
    return ($urandom_range(0, 3) == 0) ? 5'($urandom) : l[$urandom_range(0, 3)];
  endfunction

  initial begin : monitor
    exp_t e;
    ex_t  a;
    logic st, st2;
    forever begin
      @(negedge clk);
      #4;
      st = bus.ifid_stall;
      st2 = sbus.ifid_stall;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        a = '{bus.ex_valid, bus.ex_ctrl, bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data,
              bus.ex_rs1_addr, bus.ex_rs2_addr, bus.ex_rd_addr, bus.ex_imms};
        chk("ifid_stall", 512'(st), 512'(e.stall));
        chk("ifid_stall_w2", 512'(st2), 512'(e.stall));
        chk("ex_valid", 512'(a.valid), 512'(e.ex.valid));
        chk("ex_bundle", 512'(a), 512'(e.ex));
        chk("bubble_count", 512'(bus.bubble_count), 512'(sat(e.bc, 16)));
        chk("flush_count", 512'(bus.flush_count), 512'(sat(e.fc, 16)));
        chk("bubble_count_w2", 512'(sbus.bubble_count), 512'(sat(e.bc, 2)));
        chk("flush_count_w2", 512'(sbus.flush_count), 512'(sat(e.fc, 2)));
      end
    end
  end

  initial begin : driver
    rv32i_control_word lw, alu, sw;
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_CSR};
    m = '0; mbc = 0; mfc = 0;
    lw = mkc(1, 1, 0);
    alu = mkc(1, 0, 0);
    sw = mkc(0, 0, 1);
    step(0, 0, OP_IMM, alu, 0, 0, 0, 0, 0);
    step(1, 0, OP_IMM, alu, 0, 0, 0, 0, 0);
    step(1, 1, OP_LOAD, lw, 1, 0, 5, 0, 0);
    step(1, 1, OP_REG, alu, 5, 7, 6, 0, 0);
    step(1, 1, OP_REG, alu, 5, 7, 6, 0, 0);
    step(1, 1, OP_LOAD, lw, 1, 0, 0, 0, 0);
    step(1, 1, OP_REG, alu, 0, 0, 6, 0, 0);
    step(1, 1, OP_LOAD, lw, 1, 0, 5, 0, 0);
    step(1, 1, OP_LUI, alu, 5, 5, 5, 0, 0);
    step(1, 1, OP_LOAD, lw, 1, 0, 5, 0, 0);
    step(1, 1, OP_STORE, sw, 2, 5, 0, 0, 0);
    step(1, 1, OP_STORE, sw, 2, 5, 0, 0, 0);
    step(1, 1, OP_LOAD, lw, 1, 0, 5, 0, 0);
    step(1, 1, OP_REG, alu, 5, 7, 6, 0, 1);
    step(1, 1, OP_LOAD, lw, 1, 0, 5, 0, 0);
    repeat (3) step(1, 1, ops[$urandom_range(0, 9)], mkc(1, 1, 1), 5, 5, 5, 1, 1);
    step(1, 1, OP_REG, alu, 5, 7, 6, 0, 0);
    step(1, 1, OP_REG, alu, 5, 7, 6, 0, 0);
    repeat (5) begin
      step(1, 1, OP_LOAD, lw, 1, 0, 5, 0, 0);
      step(1, 1, OP_BR, mkc(0, 0, 0), 3, 5, 0, 0, 0);
    end
    step(1, 1, OP_LOAD, lw, 1, 0, 5, 0, 0);
    step(0, 1, OP_REG, alu, 5, 7, 6, 0, 0);
    step(1, 0, OP_IMM, alu, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rv32i_control_word c;
      logic [6:0] op;
      c = mkc($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1));
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      step($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0, op, c,
           pick_reg(), pick_reg(), pick_reg(), $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
